// File: rtl/frame_tx_streamer.sv
// frame_tx_streamer
// Reads the packed edge frame out of the frame buffer and streams it to the
// UART transmitter. Each frame goes out as SYNC0, SYNC1, NUM_BYTES payload
// bytes and an XOR checksum of the payload. One byte is handed to uart_tx at
// a time. The next byte is not offered until uart_tx reports idle again.
module frame_tx_streamer #(
  parameter int          NUM_BYTES = 5100,
  parameter int          ADDR_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
  parameter logic [7:0]  SYNC0     = 8'hAA,
  parameter logic [7:0]  SYNC1     = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [7:0]        rData,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              streaming,
  output logic              frame_sent,
  output logic              frame_overrun
);

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    RD,
    RWAIT,
    SEND,
    HOLD,
    CSUM,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  // ret_state remembers where HOLD goes once the byte in flight has finished.
  state_t state, state_nx;
  state_t ret_state, ret_state_nx;

  // hold_first is high only on the first HOLD cycle. uart_tx raises busy one
  // cycle late, so busy is not trusted on that cycle.
  logic              hold_first, hold_first_nx;
  logic [7:0]        payload, payload_nx;
  logic [7:0]        checksum, checksum_nx;
  logic              last_addr;

  logic [ADDR_W-1:0] rAddr_nx;
  logic              tx_start_nx;
  logic [7:0]        tx_data_nx;
  logic              streaming_nx;
  logic              frame_sent_nx;
  logic              frame_overrun_nx;

  assign last_addr = (rAddr == LAST_ADDR);

  // State register: a reset at any time abandons the frame and returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of block evaluation order.
      state     <= IDLE;
      ret_state <= IDLE;
    end else begin
      state     <= state_nx;
      ret_state <= ret_state_nx;
    end
  end

  // Next-state logic: send states move to HOLD only when uart_tx is idle.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    state_nx     = state;
    ret_state_nx = ret_state;
    unique case (state)
      IDLE: begin
        if (frame_tick) state_nx = HDR0;
      end
      HDR0: begin
        if (!tx_busy) begin
          state_nx     = HOLD;
          ret_state_nx = HDR1;
        end
      end
      HDR1: begin
        if (!tx_busy) begin
          state_nx     = HOLD;
          ret_state_nx = RD;
        end
      end
      RD:    state_nx = RWAIT;
      RWAIT: state_nx = SEND;
      SEND: begin
        if (!tx_busy) begin
          state_nx     = HOLD;
          ret_state_nx = last_addr ? CSUM : RD;
        end
      end
      CSUM: begin
        if (!tx_busy) begin
          state_nx     = HOLD;
          ret_state_nx = DONE;
        end
      end
      HOLD: begin
        if (!hold_first && !tx_busy) state_nx = ret_state;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output and datapath next values. All of them are registered below.
  always_comb begin
    rAddr_nx         = rAddr;
    tx_start_nx      = 1'b0;
    tx_data_nx       = tx_data;
    streaming_nx     = streaming;
    payload_nx       = payload;
    checksum_nx      = checksum;
    frame_sent_nx    = (state_nx == DONE);
    hold_first_nx    = (state_nx == HOLD) && (state != HOLD);
    frame_overrun_nx = frame_tick && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          streaming_nx = 1'b1;
          rAddr_nx     = '0;
          checksum_nx  = '0;
        end
      end
      HDR0: begin
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = SYNC0;
        end
      end
      HDR1: begin
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = SYNC1;
        end
      end
      RWAIT: begin
        // The RAM has returned the byte at rAddr on this cycle.
        payload_nx  = rData;
        checksum_nx = checksum ^ rData;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = payload;
          // Stop at the last byte so the address never wraps within a frame.
          if (!last_addr) rAddr_nx = rAddr + ADDR_W'(1);
        end
      end
      CSUM: begin
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = checksum;
        end
      end
      DONE: begin
        streaming_nx = 1'b0;
        rAddr_nx     = '0;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath: every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rAddr         <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      streaming     <= 1'b0;
      frame_sent    <= 1'b0;
      frame_overrun <= 1'b0;
      hold_first    <= 1'b0;
      payload       <= '0;
      checksum      <= '0;
    end else begin
      rAddr         <= rAddr_nx;
      tx_start      <= tx_start_nx;
      tx_data       <= tx_data_nx;
      streaming     <= streaming_nx;
      frame_sent    <= frame_sent_nx;
      frame_overrun <= frame_overrun_nx;
      hold_first    <= hold_first_nx;
      payload       <= payload_nx;
      checksum      <= checksum_nx;
    end
  end

endmodule

// File: tb/tb_frame_tx_streamer.sv
// tb_frame_tx_streamer
// Drives two streamers: a 4-byte frame instance for the protocol scenarios and
// a full-size 5100-byte instance. Expected bytes are queued when a frame is
// launched. They are popped and compared as tx_start pulses appear.
module tb_frame_tx_streamer;

  localparam int S_N = 4;
  localparam int F_N = 5100;
  localparam int F_AW = $clog2(F_N);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- small instance ----------------
  logic            s_tick = 1'b0;
  logic [1:0]      s_rAddr;
  logic [7:0]      s_rData = '0;
  logic            s_tx_busy, s_tx_start, s_streaming, s_frame_sent, s_frame_overrun;
  logic [7:0]      s_tx_data;
  logic            s_force_busy = 1'b0;
  int              s_busy_cnt = 0;
  logic            s_busy_q = 1'b0;
  logic [7:0]      s_ram [S_N];
  logic [7:0]      s_exp_q [$];
  logic [7:0]      s_exp_b;
  int              s_start_cnt = 0, s_sent_cnt = 0, s_ovr_cnt = 0;

  frame_tx_streamer #(.NUM_BYTES(S_N)) dut_small (
    .clk(clk), .reset(reset), .frame_tick(s_tick), .rAddr(s_rAddr), .rData(s_rData),
    .tx_busy(s_tx_busy), .tx_start(s_tx_start), .tx_data(s_tx_data),
    .streaming(s_streaming), .frame_sent(s_frame_sent), .frame_overrun(s_frame_overrun)
  );

  assign s_tx_busy = (s_busy_cnt > 0) || s_force_busy;

  // Synchronous RAM, UART busy model (10 cycles) and pre-edge busy sample.
  always @(posedge clk) begin
    s_rData  <= s_ram[s_rAddr];
    s_busy_q <= s_tx_busy;
    if (s_tx_start) s_busy_cnt <= 10;
    else if (s_busy_cnt > 0) s_busy_cnt <= s_busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (s_tx_start) begin
      s_start_cnt++;
      checks++;
      if (s_exp_q.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected_start: tx_data=%02h, expected no tx_start", s_tx_data);
      end else begin
        s_exp_b = s_exp_q.pop_front();
        if (s_tx_data !== s_exp_b) begin
          errors++;
          $display("FAIL small_tx_data: got %02h, expected %02h", s_tx_data, s_exp_b);
        end
      end
      checks++;
      if (s_busy_q !== 1'b0) begin
        errors++;
        $display("FAIL small_start_while_busy: busy at decision edge=%b, expected 0", s_busy_q);
      end
      checks++;
      if (s_streaming !== 1'b1) begin
        errors++;
        $display("FAIL small_streaming_at_start: got %b, expected 1", s_streaming);
      end
    end
    if (s_frame_sent) s_sent_cnt++;
    if (s_frame_overrun) s_ovr_cnt++;
  end

  // ---------------- full-size instance ----------------
  logic            f_tick = 1'b0;
  logic [F_AW-1:0] f_rAddr;
  logic [7:0]      f_rData = '0;
  logic            f_tx_busy, f_tx_start, f_streaming, f_frame_sent, f_frame_overrun;
  logic [7:0]      f_tx_data;
  int              f_busy_cnt = 0;
  logic [7:0]      f_ram [F_N];
  logic [7:0]      f_exp_q [$];
  logic [7:0]      f_exp_b;
  logic [7:0]      f_last_data = '0;
  int              f_start_cnt = 0, f_sent_cnt = 0;
  int              f_addr_prev = 0, f_addr_max = 0, f_addr_err = 0;

  frame_tx_streamer #(.NUM_BYTES(F_N)) dut_full (
    .clk(clk), .reset(reset), .frame_tick(f_tick), .rAddr(f_rAddr), .rData(f_rData),
    .tx_busy(f_tx_busy), .tx_start(f_tx_start), .tx_data(f_tx_data),
    .streaming(f_streaming), .frame_sent(f_frame_sent), .frame_overrun(f_frame_overrun)
  );

  assign f_tx_busy = (f_busy_cnt > 0);

  // Synchronous RAM and a fast UART model (2 busy cycles) to keep the run short.
  always @(posedge clk) begin
    f_rData <= f_ram[f_rAddr];
    if (f_tx_start) f_busy_cnt <= 2;
    else if (f_busy_cnt > 0) f_busy_cnt <= f_busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (f_tx_start) begin
      f_start_cnt++;
      f_last_data = f_tx_data;
      checks++;
      if (f_exp_q.size() == 0) begin
        errors++;
        $display("FAIL full_unexpected_start: tx_data=%02h, expected no tx_start", f_tx_data);
      end else begin
        f_exp_b = f_exp_q.pop_front();
        if (f_tx_data !== f_exp_b) begin
          errors++;
          $display("FAIL full_tx_data: byte %0d got %02h, expected %02h",
                   f_start_cnt - 1, f_tx_data, f_exp_b);
        end
      end
    end
    if (f_frame_sent) f_sent_cnt++;
    if (int'(f_rAddr) != f_addr_prev) begin
      if (int'(f_rAddr) != f_addr_prev + 1 && f_rAddr != '0) f_addr_err++;
      f_addr_prev = int'(f_rAddr);
      if (f_addr_prev > f_addr_max) f_addr_max = f_addr_prev;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_small_frame();
    logic [7:0] cs;
    cs = '0;
    s_exp_q.push_back(8'hAA);
    s_exp_q.push_back(8'h55);
    for (int i = 0; i < S_N; i++) begin
      s_exp_q.push_back(s_ram[i]);
      cs ^= s_ram[i];
    end
    s_exp_q.push_back(cs);
  endtask

  task automatic pulse_small_tick();
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic clear_small_counts();
    s_start_cnt = 0;
    s_sent_cnt  = 0;
    s_ovr_cnt   = 0;
  endtask

  // Waits for frame_sent and counts cycles where streaming dropped before it.
  task automatic wait_small_sent(input int budget, output bit ok, output int drops);
    ok = 1'b0;
    drops = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (s_frame_sent) begin
        ok = 1'b1;
        break;
      end
      if (!s_streaming) drops++;
    end
  endtask

  task automatic wait_small_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (s_start_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({s_rAddr, s_tx_start, s_tx_data, s_streaming, s_frame_sent, s_frame_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_small_outputs: got %h, expected 0",
               {s_rAddr, s_tx_start, s_tx_data, s_streaming, s_frame_sent, s_frame_overrun});
    end
    checks++;
    if ({f_rAddr, f_tx_start, f_tx_data, f_streaming, f_frame_sent, f_frame_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_full_outputs: got %h, expected 0",
               {f_rAddr, f_tx_start, f_tx_data, f_streaming, f_frame_sent, f_frame_overrun});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (s_streaming !== 1'b0 || s_start_cnt != 0) begin
      errors++;
      $display("FAIL reset_idle_after_release: streaming=%b starts=%0d, expected 0/0",
               s_streaming, s_start_cnt);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int drops;
    clear_small_counts();
    push_small_frame();
    pulse_small_tick();
    wait_small_sent(500, ok, drops);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_frame_sent_timeout: no frame_sent within 500 cycles, expected one");
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL basic_streaming_drop: %0d low cycles, expected 0", drops);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (s_start_cnt != 7 || s_sent_cnt != 1 || s_ovr_cnt != 0) begin
      errors++;
      $display("FAIL basic_counts: starts=%0d sent=%0d overrun=%0d, expected 7/1/0",
               s_start_cnt, s_sent_cnt, s_ovr_cnt);
    end
    checks++;
    if (s_exp_q.size() != 0 || s_streaming !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_state: queue=%0d streaming=%b, expected 0/0",
               s_exp_q.size(), s_streaming);
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int drops;
    clear_small_counts();
    push_small_frame();
    s_force_busy = 1'b1;
    pulse_small_tick();
    repeat (49) @(negedge clk);
    checks++;
    if (s_start_cnt != 0) begin
      errors++;
      $display("FAIL busy_hold_start: %0d starts while busy, expected 0", s_start_cnt);
    end
    s_force_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tx_start !== 1'b1 || s_tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL busy_release_first_byte: tx_start=%b tx_data=%02h, expected 1/AA",
               s_tx_start, s_tx_data);
    end
    wait_small_sent(500, ok, drops);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || s_start_cnt != 7 || s_exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_hold_frame: sent=%b starts=%0d queue=%0d, expected 1/7/0",
               ok, s_start_cnt, s_exp_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int drops;
    clear_small_counts();
    push_small_frame();
    pulse_small_tick();
    wait_small_starts(4, 300, ok);
    pulse_small_tick();
    wait_small_sent(500, ok, drops);
    repeat (60) @(negedge clk);
    checks++;
    if (s_ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, expected 1", s_ovr_cnt);
    end
    checks++;
    if (!ok || s_start_cnt != 7 || s_sent_cnt != 1 || s_streaming !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_second_frame: sent=%b starts=%0d frames=%0d streaming=%b, expected 1/7/1/0",
               ok, s_start_cnt, s_sent_cnt, s_streaming);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int drops;
    clear_small_counts();
    push_small_frame();
    pulse_small_tick();
    wait_small_starts(4, 300, ok);
    checks++;
    if (!ok || s_tx_data !== 8'h02) begin
      errors++;
      $display("FAIL midreset_reach_byte2: reached=%b tx_data=%02h, expected 1/02", ok, s_tx_data);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({s_rAddr, s_tx_start, s_tx_data, s_streaming, s_frame_sent, s_frame_overrun} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, expected 0",
               {s_rAddr, s_tx_start, s_tx_data, s_streaming, s_frame_sent, s_frame_overrun});
    end
    s_exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (s_start_cnt != 4 || s_streaming !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_resume: starts=%0d streaming=%b, expected 4/0",
               s_start_cnt, s_streaming);
    end
    push_small_frame();
    pulse_small_tick();
    wait_small_starts(5, 300, ok);
    checks++;
    if (!ok || s_rAddr !== 2'd0 || s_tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL midreset_restart: started=%b rAddr=%0d tx_data=%02h, expected 1/0/AA",
               ok, s_rAddr, s_tx_data);
    end
    wait_small_sent(500, ok, drops);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || s_start_cnt != 11 || s_exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_new_frame: sent=%b starts=%0d queue=%0d, expected 1/11/0",
               ok, s_start_cnt, s_exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int drops;
    clear_small_counts();
    push_small_frame();
    push_small_frame();
    pulse_small_tick();
    wait_small_sent(500, ok1, drops);
    // frame_sent is high in DONE; the following cycle is IDLE and must accept.
    @(negedge clk);
    pulse_small_tick();
    wait_small_sent(500, ok2, drops);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok1 || !ok2 || s_sent_cnt != 2 || s_start_cnt != 14) begin
      errors++;
      $display("FAIL b2b_frames: sent=%b%b frames=%0d starts=%0d, expected 11/2/14",
               ok1, ok2, s_sent_cnt, s_start_cnt);
    end
    checks++;
    if (s_ovr_cnt != 0 || s_exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_overrun: overrun=%0d queue=%0d, expected 0/0", s_ovr_cnt, s_exp_q.size());
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] cs;
    bit ok;
    cs = '0;
    f_exp_q.push_back(8'hAA);
    f_exp_q.push_back(8'h55);
    for (int i = 0; i < F_N; i++) begin
      f_exp_q.push_back(f_ram[i]);
      cs ^= f_ram[i];
    end
    f_exp_q.push_back(cs);
    f_tick = 1'b1;
    @(negedge clk);
    f_tick = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      if (f_frame_sent) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_timeout: no frame_sent within 60000 cycles, expected one");
    end
    repeat (5) @(negedge clk);
    checks++;
    if (f_start_cnt != F_N + 3 || f_exp_q.size() != 0 || f_sent_cnt != 1) begin
      errors++;
      $display("FAIL full_byte_count: starts=%0d queue=%0d frames=%0d, expected %0d/0/1",
               f_start_cnt, f_exp_q.size(), f_sent_cnt, F_N + 3);
    end
    checks++;
    if (f_addr_err != 0 || f_addr_max != F_N - 1) begin
      errors++;
      $display("FAIL full_addr_sweep: step errors=%0d max=%0d, expected 0/%0d",
               f_addr_err, f_addr_max, F_N - 1);
    end
    checks++;
    if (f_last_data !== cs) begin
      errors++;
      $display("FAIL full_checksum: got %02h, expected %02h", f_last_data, cs);
    end
  endtask

  initial begin
    s_ram[0] = 8'h01;
    s_ram[1] = 8'h02;
    s_ram[2] = 8'h04;
    s_ram[3] = 8'h08;
    for (int i = 0; i < F_N; i++) f_ram[i] = i[7:0];
    test_reset();
    test_basic_frame();
    test_busy_hold();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
